// File: rtl/ovl_fire_collector_if.sv
// Event stream from the fire collector to its consumer (firmware or bench).
// The master drives the FIFO head; the slave answers with ready.
interface ovl_fire_collector_if #(
  parameter int unsigned TS_WIDTH = 16
);
  logic                evt_valid;
  logic                evt_ready;
  logic [3:0]          evt_id;
  logic [2:0]          evt_type;
  logic [TS_WIDTH-1:0] evt_time;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_type,
    output evt_time,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_type,
    input  evt_time,
    output evt_ready
  );
endinterface

// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fire buses into a timestamped first-word-fall-through
// event FIFO, with saturating per-checker violation counters and sticky flags.
module ovl_fire_collector #(
  parameter int unsigned NUM_CHECKERS = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned TS_WIDTH     = 16,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [3*NUM_CHECKERS-1:0]         fire_bus,
  ovl_fire_collector_if.master              evt,
  output logic [NUM_CHECKERS*CNT_WIDTH-1:0] viol_count,
  output logic                              any_violation,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [3:0]          id;
    logic [2:0]          kind;
    logic [TS_WIDTH-1:0] stamp;
  } entry_t;

  logic [TS_WIDTH-1:0]     ts;
  logic [NUM_CHECKERS-1:0] pend;
  logic [2:0]              pend_type [NUM_CHECKERS];
  logic [TS_WIDTH-1:0]     pend_time [NUM_CHECKERS];
  logic [CNT_WIDTH-1:0]    cnt       [NUM_CHECKERS];

  entry_t                  mem [FIFO_DEPTH];
  entry_t                  last_head;
  entry_t                  head;
  entry_t                  push_entry;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level;

  logic [2:0]              fire [NUM_CHECKERS];
  logic [NUM_CHECKERS-1:0] fired;
  logic [NUM_CHECKERS-1:0] took;
  logic [NUM_CHECKERS-1:0] merge;
  logic [NUM_CHECKERS-1:0] assert_hit;
  logic [3:0]              sel;
  logic                    found;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    sample;

  assign full   = (level == LW'(FIFO_DEPTH));
  assign pop    = (level != '0) && evt.evt_ready;
  assign push   = found && !clear && (!full || pop);
  assign sample = enable && !clear;

  // Lowest-index pending checker wins the single push slot.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
      if (pend[k] && !found) begin
        found = 1'b1;
        sel   = 4'(k);
      end
    end
  end

  always_comb begin
    push_entry.id    = sel;
    push_entry.kind  = '0;
    push_entry.stamp = '0;
    for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
      if (sel == 4'(k)) begin
        push_entry.kind  = pend_type[k];
        push_entry.stamp = pend_time[k];
      end
    end
  end

  // A checker drained this edge starts a fresh entry, so only a still-pending
  // entry counts as a merge.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
      fire[k]       = fire_bus[3*k +: 3];
      fired[k]      = sample && (fire[k] != 3'b000);
      took[k]       = push && (sel == 4'(k));
      merge[k]      = fired[k] && pend[k] && !took[k];
      assert_hit[k] = sample && fire[k][0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ts            <= '0;
      pend          <= '0;
      any_violation <= 1'b0;
      overflow      <= 1'b0;
      for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
        pend_type[k] <= '0;
        pend_time[k] <= '0;
        cnt[k]       <= '0;
      end
    end else begin
      if (enable) begin
        ts <= ts + TS_WIDTH'(1);
      end

      if (clear) begin
        pend          <= '0;
        any_violation <= 1'b0;
        overflow      <= 1'b0;
        for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
          pend_type[k] <= '0;
          cnt[k]       <= '0;
        end
      end else begin
        if (|assert_hit) begin
          any_violation <= 1'b1;
        end
        if (|merge) begin
          overflow <= 1'b1;
        end
        for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
          if (fired[k]) begin
            pend[k] <= 1'b1;
            if (merge[k]) begin
              pend_type[k] <= pend_type[k] | fire[k];
            end else begin
              pend_type[k] <= fire[k];
              pend_time[k] <= ts;
            end
          end else if (took[k]) begin
            pend[k]      <= 1'b0;
            pend_type[k] <= '0;
          end
          if (assert_hit[k] && (cnt[k] != '1)) begin
            cnt[k] <= cnt[k] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_head <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_head <= mem[rd_ptr];
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Once drained, the outputs keep showing the last entry handed out.
  assign head          = (level != '0) ? mem[rd_ptr] : last_head;
  assign evt.evt_valid = (level != '0);
  assign evt.evt_id    = head.id;
  assign evt.evt_type  = head.kind;
  assign evt.evt_time  = head.stamp;
  assign fifo_level    = level;

  always_comb begin
    viol_count = '0;
    for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
      viol_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
    end
  end

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Randomized and directed stimulus for ovl_fire_collector, checked every cycle
// against a queue-based reference model.
module tb_ovl_fire_collector;
  localparam int unsigned N    = 4;
  localparam int unsigned D    = 8;
  localparam int unsigned TSW  = 6;
  localparam int unsigned CW   = 8;
  localparam int          TMOD = 1 << TSW;
  localparam int          CMAX = (1 << CW) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              clear;
  logic [3*N-1:0]    fire_bus;
  logic [N*CW-1:0]   viol_count;
  logic              any_violation;
  logic              overflow;
  logic [$clog2(D):0] fifo_level;

  ovl_fire_collector_if #(.TS_WIDTH(TSW)) evt_if ();

  ovl_fire_collector #(
    .NUM_CHECKERS(N),
    .FIFO_DEPTH  (D),
    .TS_WIDTH    (TSW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .fire_bus     (fire_bus),
    .evt          (evt_if),
    .viol_count   (viol_count),
    .any_violation(any_violation),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    int id;
    int kind;
    int stamp;
  } ev_t;

  int  checks   = 0;
  int  failures = 0;

  int  m_ts;
  bit  m_pend  [N];
  int  m_ptype [N];
  int  m_ptime [N];
  int  m_cnt   [N];
  bit  m_any;
  bit  m_ovf;
  ev_t q[$];
  ev_t m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: events are records in a queue; pending slots are plain arrays.
  function automatic void model_edge();
    ev_t         e;
    bit          pop;
    int          sel;
    logic [2:0]  f;
    if (!reset) begin
      m_ts = 0; m_any = 0; m_ovf = 0;
      q.delete();
      m_last = '{0, 0, 0};
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 0; m_ptype[k] = 0; m_ptime[k] = 0; m_cnt[k] = 0;
      end
      return;
    end
    pop = (q.size() > 0) && evt_if.evt_ready;
    sel = -1;
    for (int k = 0; k < N; k++) if (m_pend[k] && sel < 0) sel = k;
    e = '{0, 0, 0};
    if (sel >= 0 && !clear && (q.size() < D || pop)) begin
      e = '{sel, m_ptype[sel], m_ptime[sel]};
      m_pend[sel] = 0;
      m_ptype[sel] = 0;
    end else begin
      sel = -1;
    end
    if (pop) m_last = q.pop_front();
    if (sel >= 0) q.push_back(e);
    if (clear) begin
      m_any = 0; m_ovf = 0;
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 0; m_ptype[k] = 0; m_cnt[k] = 0;
      end
    end else if (enable) begin
      for (int k = 0; k < N; k++) begin
        f = fire_bus[3*k +: 3];
        if (f != 3'b000) begin
          if (m_pend[k]) begin
            m_ptype[k] = m_ptype[k] | int'(f);
            m_ovf = 1;
          end else begin
            m_pend[k] = 1; m_ptype[k] = int'(f); m_ptime[k] = m_ts;
          end
          if (f[0]) begin
            m_any = 1;
            if (m_cnt[k] < CMAX) m_cnt[k]++;
          end
        end
      end
    end
    if (enable) m_ts = (m_ts + 1) % TMOD;
  endfunction

  task automatic compare_all();
    ev_t h;
    h = (q.size() > 0) ? q[0] : m_last;
    check("evt_valid", 64'(evt_if.evt_valid), 64'(q.size() > 0));
    check("evt_id",    64'(evt_if.evt_id),    64'(h.id));
    check("evt_type",  64'(evt_if.evt_type),  64'(h.kind));
    check("evt_time",  64'(evt_if.evt_time),  64'(h.stamp));
    check("fifo_level", 64'(fifo_level),      64'(q.size()));
    check("any_violation", 64'(any_violation), 64'(m_any));
    check("overflow",  64'(overflow),         64'(m_ovf));
    for (int k = 0; k < N; k++)
      check($sformatf("viol_count%0d", k), 64'(viol_count[k*CW +: CW]), 64'(m_cnt[k]));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 1'b1; enable = 1'b1; clear = 1'b0; fire_bus = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0; fire_bus = '0; clear = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [2:0] rf;
  int         ready_pct;

  initial begin
    idle_inputs();
    evt_if.evt_ready = 1'b0;
    do_reset();
    check("reset_valid", 64'(evt_if.evt_valid), 64'd0);
    check("reset_level", 64'(fifo_level), 64'd0);

    // Simultaneous fires on checkers 0, 2, 3 with the consumer stalled.
    fire_bus = 12'b001_001_000_001;
    step();
    fire_bus = '0;
    repeat (4) step();
    check("simul_level", 64'(fifo_level), 64'd3);
    evt_if.evt_ready = 1'b1;
    repeat (4) step();

    // Backpressure: checker 1 fires every other cycle into a stalled FIFO.
    do_reset();
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fire_bus = (i % 2 == 0) ? 12'b000_000_001_000 : 12'b0;
      step();
    end
    fire_bus = '0;
    step();
    check("full_level", 64'(fifo_level), 64'd8);
    check("full_overflow", 64'(overflow), 64'd1);
    evt_if.evt_ready = 1'b1;
    repeat (12) step();

    // Saturation, then cover-only fires that must not count.
    do_reset();
    fire_bus = 12'b001_000_000_000;
    repeat (300) step();
    fire_bus = 12'b100_000_000_000;
    repeat (5) step();
    fire_bus = '0;
    repeat (3) step();
    check("saturated", 64'(viol_count[3*CW +: CW]), 64'd255);

    // Clear keeps queued events; reset drops them.
    do_reset();
    evt_if.evt_ready = 1'b0;
    fire_bus = 12'b000_000_001_001;
    step();
    fire_bus = '0;
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_level", 64'(fifo_level), 64'd2);
    check("clear_any", 64'(any_violation), 64'd0);
    check("clear_cnt0", 64'(viol_count[CW-1:0]), 64'd0);
    step();
    do_reset();
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_valid", 64'(evt_if.evt_valid), 64'd0);

    // Random traffic: enable gaps, clears, occasional resets, varying drain.
    for (int blk = 0; blk < 20; blk++) begin
      ready_pct = $urandom_range(0, 100);
      for (int i = 0; i < 150; i++) begin
        reset  = ($urandom_range(0, 299) != 0);
        enable = ($urandom_range(0, 9) != 0);
        clear  = ($urandom_range(0, 59) == 0);
        evt_if.evt_ready = ($urandom_range(0, 99) < ready_pct);
        for (int k = 0; k < N; k++) begin
          rf = 3'($urandom_range(1, 7));
          fire_bus[3*k +: 3] = ($urandom_range(0, 9) < 3) ? rf : 3'b000;
        end
        step();
      end
    end

    idle_inputs();
    evt_if.evt_ready = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
